// File: rtl/i2s_pkg.sv
// Shared types and frame geometry for the MSB-justified I2S receiver.
package i2s_pkg;

    localparam int unsigned FRAME_BITS = 256;
    localparam int unsigned SLOT_BITS  = 32;
    localparam int unsigned BIT_IDX_W  = $clog2(FRAME_BITS);
    localparam int unsigned SLOT_IDX_W = $clog2(SLOT_BITS);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSeek    = 2'd1,
        StCapture = 2'd2
    } state_t;

    // True when the bit index sits on a slot boundary (where lrclk must toggle).
    function automatic logic slot_boundary(input logic [BIT_IDX_W-1:0] idx);
        return idx[SLOT_IDX_W-1:0] == '0;
    endfunction

endpackage

// File: rtl/i2s_input_sync.sv
// Two-flop synchronizers for bclk/lrclk/data plus a bclk rising-edge detector.
module i2s_input_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic bclk,
    input  logic lrclk,
    input  logic data,
    output logic bclk_rise_c,
    output logic lrclk_sync,
    output logic data_sync
);

    logic [2:0] meta_q;
    logic [2:0] sync_q;
    logic       bclk_prev_q;

    // All three pins share the same latency so data/lrclk line up with the bclk edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q      <= '0;
            sync_q      <= '0;
            bclk_prev_q <= 1'b0;
        end else begin
            meta_q      <= {bclk, lrclk, data};
            sync_q      <= meta_q;
            bclk_prev_q <= sync_q[2];
        end
    end

    assign bclk_rise_c = sync_q[2] & ~bclk_prev_q;
    assign lrclk_sync  = sync_q[1];
    assign data_sync   = sync_q[0];

endmodule

// File: rtl/i2s_msb_receiver.sv
// MSB-justified 8-slot I2S receiver writing bits into a circular frame RAM.
// Define I2S_RX_WATCHDOG_EN to drop lock when bclk stalls for WDOG_CYCLES clocks.
module i2s_msb_receiver
    import i2s_pkg::*;
#(
    parameter int unsigned CIRC_BUF_BITS = 3,
    parameter int unsigned WDOG_CYCLES   = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       enable_i,
    input  logic                       i2s_bclk_i,
    input  logic                       i2s_lrclk_i,
    input  logic                       i2s_data_i,
    output logic [CIRC_BUF_BITS+7:0]   ram_write_addr_o,
    output logic                       ram_data_o,
    output logic                       ram_we_o,
    output logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_o,
    output logic                       locked_o,
    output logic                       frame_error_o
);

    localparam int unsigned ADDR_W = CIRC_BUF_BITS + BIT_IDX_W;

    logic bclk_rise_c;
    logic lrclk_sync;
    logic data_sync;

    i2s_input_sync u_sync (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .bclk        (i2s_bclk_i),
        .lrclk       (i2s_lrclk_i),
        .data        (i2s_data_i),
        .bclk_rise_c (bclk_rise_c),
        .lrclk_sync  (lrclk_sync),
        .data_sync   (data_sync)
    );

    state_t                   state_q, state_d;
    logic [BIT_IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [CIRC_BUF_BITS-1:0] wr_frame_q, wr_frame_d;
    logic [CIRC_BUF_BITS-1:0] last_good_q, last_good_d;
    logic                     lr_prev_q, lr_prev_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic                     data_q, data_d;
    logic                     we_q, we_d;
    logic                     err_q, err_d;
    logic                     locked_q, locked_d;
    logic                     done_q, done_d;
    logic                     timeout_c;
    logic                     lr_toggle_c;
    logic                     misalign_c;

`ifdef I2S_RX_WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt_q;

    // Counts clocks since the last bclk edge while capturing; saturates at the limit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_cnt_q <= '0;
        end else if ((state_q != StCapture) || bclk_rise_c) begin
            wdog_cnt_q <= '0;
        end else if (wdog_cnt_q != WDOG_W'(WDOG_CYCLES)) begin
            wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
        end
    end

    assign timeout_c = (state_q == StCapture) && (wdog_cnt_q == WDOG_W'(WDOG_CYCLES));
`else
    assign timeout_c = 1'b0;
`endif

    // Slot boundaries need an lrclk toggle; anywhere else a toggle means we slipped.
    assign lr_toggle_c = lrclk_sync ^ lr_prev_q;
    assign misalign_c  = slot_boundary(bit_idx_q)
                       ? (!lr_toggle_c && (bit_idx_q != '0))
                       : lr_toggle_c;

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        wr_frame_d  = wr_frame_q;
        last_good_d = last_good_q;
        lr_prev_d   = lr_prev_q;
        addr_d      = addr_q;
        data_d      = data_q;
        we_d        = 1'b0;
        err_d       = 1'b0;
        done_d      = 1'b0;

        // Publish the frame one cycle after its last bit was written.
        if (done_q) begin
            last_good_d = addr_q[ADDR_W-1 -: CIRC_BUF_BITS];
        end

        if (bclk_rise_c) begin
            lr_prev_d = lrclk_sync;
        end

        case (state_q)
            StIdle: begin
                bit_idx_d = '0;
                if (enable_i) begin
                    state_d = StSeek;
                end
            end

            StSeek: begin
                bit_idx_d = '0;
                if (bclk_rise_c && lrclk_sync && !lr_prev_q) begin
                    state_d   = StCapture;
                    we_d      = 1'b1;
                    addr_d    = {wr_frame_q, BIT_IDX_W'(0)};
                    data_d    = data_sync;
                    bit_idx_d = BIT_IDX_W'(1);
                end
            end

            StCapture: begin
                if (timeout_c || (bclk_rise_c && misalign_c)) begin
                    state_d   = StSeek;
                    bit_idx_d = '0;
                    err_d     = 1'b1;
                end else if (bclk_rise_c) begin
                    we_d      = 1'b1;
                    addr_d    = {wr_frame_q, bit_idx_q};
                    data_d    = data_sync;
                    bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    if (bit_idx_q == BIT_IDX_W'(FRAME_BITS - 1)) begin
                        wr_frame_d = wr_frame_q + CIRC_BUF_BITS'(1);
                        done_d     = 1'b1;
                    end
                end
            end

            default: begin
                state_d   = StIdle;
                bit_idx_d = '0;
            end
        endcase

        // Disable wins over everything: abort quietly, keep the frame slot for reuse.
        if (!enable_i) begin
            state_d    = StIdle;
            bit_idx_d  = '0;
            wr_frame_d = wr_frame_q;
            we_d       = 1'b0;
            err_d      = 1'b0;
            done_d     = 1'b0;
        end

        locked_d = (state_d == StCapture);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            bit_idx_q   <= '0;
            wr_frame_q  <= '0;
            last_good_q <= '0;
            lr_prev_q   <= 1'b0;
            addr_q      <= '0;
            data_q      <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            locked_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            wr_frame_q  <= wr_frame_d;
            last_good_q <= last_good_d;
            lr_prev_q   <= lr_prev_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            we_q        <= we_d;
            err_q       <= err_d;
            locked_q    <= locked_d;
            done_q      <= done_d;
        end
    end

    assign ram_write_addr_o      = addr_q;
    assign ram_data_o            = data_q;
    assign ram_we_o              = we_q;
    assign last_good_frame_idx_o = last_good_q;
    assign locked_o              = locked_q;
    assign frame_error_o         = err_q;

endmodule

// File: tb/tb_i2s_msb_receiver.sv
// Self-checking bench for i2s_msb_receiver: frame table plus scoreboard of RAM writes.
module tb_i2s_msb_receiver;

    localparam int CB = 3;
    localparam int AW = CB + 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          bclk;
    logic          lrclk;
    logic          data;
    logic [AW-1:0] ram_write_addr;
    logic          ram_data;
    logic          ram_we;
    logic [CB-1:0] last_good;
    logic          locked;
    logic          frame_error;

    always #5 clk = ~clk;

    i2s_msb_receiver #(.CIRC_BUF_BITS(CB), .WDOG_CYCLES(64)) u_dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .enable_i              (enable),
        .i2s_bclk_i            (bclk),
        .i2s_lrclk_i           (lrclk),
        .i2s_data_i            (data),
        .ram_write_addr_o      (ram_write_addr),
        .ram_data_o            (ram_data),
        .ram_we_o              (ram_we),
        .last_good_frame_idx_o (last_good),
        .locked_o              (locked),
        .frame_error_o         (frame_error)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          d;
    } wr_t;

    typedef struct {
        logic [31:0] word;
        int          err_bit;
        int          exp_errs;
        logic [CB-1:0] exp_last;
        logic        exp_locked;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            rise_cyc = 0;
    int            err_seen = 0;
    logic [CB-1:0] exp_frame = '0;
    wr_t           exp_q[$];
    wr_t           mon_e;
    vec_t          vecs[10];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard: every RAM write must match the oldest pending expectation.
    always @(negedge clk) begin
        if (frame_error) err_seen++;
        if (rst_n && ram_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %0h data %b, none expected", ram_write_addr, ram_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (ram_write_addr !== mon_e.addr || ram_data !== mon_e.d) begin
                    errors++;
                    $display("FAIL ram_write: got addr %0h data %b expected addr %0h data %b",
                             ram_write_addr, ram_data, mon_e.addr, mon_e.d);
                end
            end
            checks++;
            if (cyc - rise_cyc != 3) begin
                errors++;
                $display("FAIL we_latency: got %0d cycles expected 3", cyc - rise_cyc);
            end
        end
    end

    task automatic send_bit(input logic lr, input logic d);
        @(posedge clk); #2;
        bclk = 1'b0; lrclk = lr; data = d;
        repeat (4) @(posedge clk);
        #2;
        bclk = 1'b1;
        rise_cyc = cyc;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_pad(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0);
    endtask

    // Sends bits 0..stop_bit-1 of a frame; err_bit >= 0 toggles lrclk early there and stops.
    task automatic send_frame(input logic [31:0] word, input int err_bit, input int stop_bit);
        wr_t  e;
        logic lr;
        logic d;
        for (int i = 0; i < stop_bit; i++) begin
            lr = ((i / 32) % 2) == 0;
            d  = word[31 - (i % 32)];
            if (i == err_bit) begin
                send_bit(~lr, d);
                return;
            end
            e.addr = {exp_frame, 8'(i)};
            e.d    = d;
            exp_q.push_back(e);
            send_bit(lr, d);
        end
        if (err_bit < 0 && stop_bit == 256) exp_frame = exp_frame + CB'(1);
    endtask

    initial begin
        int e0;

        vecs[0] = '{32'hA5A5_A5A5, -1, 0, 3'd0, 1'b1};
        vecs[1] = '{32'h1234_5678, -1, 0, 3'd1, 1'b1};
        vecs[2] = '{32'hFFFF_0000, 40, 1, 3'd1, 1'b0};
        vecs[3] = '{32'h0F0F_0F0F, -1, 0, 3'd2, 1'b1};
        vecs[4] = '{32'hDEAD_BEEF, -1, 0, 3'd3, 1'b1};
        vecs[5] = '{32'h8000_0001, -1, 0, 3'd4, 1'b1};
        vecs[6] = '{32'hC3C3_C3C3, -1, 0, 3'd5, 1'b1};
        vecs[7] = '{32'h7FFF_FFFE, -1, 0, 3'd6, 1'b1};
        vecs[8] = '{32'h55AA_55AA, -1, 0, 3'd7, 1'b1};
        vecs[9] = '{32'hFFFF_FFFF, -1, 0, 3'd0, 1'b1};

        rst_n = 1'b0; enable = 1'b0; bclk = 1'b0; lrclk = 1'b0; data = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_addr",      32'(ram_write_addr), 32'h0);
        check("reset_we",        32'(ram_we), 32'h0);
        check("reset_last_good", 32'(last_good), 32'h0);
        check("reset_locked",    32'(locked), 32'h0);
        check("reset_frame_err", 32'(frame_error), 32'h0);

        #2 rst_n = 1'b1;
        enable = 1'b1;
        send_pad(4);
        check("seek_not_locked", 32'(locked), 32'h0);

        for (int k = 0; k < 10; k++) begin
            e0 = err_seen;
            send_frame(vecs[k].word, vecs[k].err_bit, 256);
            if (vecs[k].err_bit >= 0) send_pad(3);
            repeat (2) @(posedge clk);
            #1;
            check("table_last_good", 32'(last_good), 32'(vecs[k].exp_last));
            check("table_err_count", 32'(err_seen - e0), 32'(vecs[k].exp_errs));
            check("table_locked",    32'(locked), 32'(vecs[k].exp_locked));
        end

        // bclk stall mid-frame
        e0 = err_seen;
        send_frame(32'h9696_6969, -1, 10);
        repeat (30) @(posedge clk);
        #1;
        check("stall_locked_early", 32'(locked), 32'h1);
        repeat (70) @(posedge clk);
        #1;
`ifdef I2S_RX_WATCHDOG_EN
        check("stall_locked_late", 32'(locked), 32'h0);
        check("stall_err_count",   32'(err_seen - e0), 32'h1);
`else
        check("stall_locked_late", 32'(locked), 32'h1);
        check("stall_err_count",   32'(err_seen - e0), 32'h0);
`endif

        // disable aborts quietly; capture resumes into the same slot
        e0 = err_seen;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("disable_locked", 32'(locked), 32'h0);
        send_pad(3);
        check("disable_no_err", 32'(err_seen - e0), 32'h0);
        enable = 1'b1;
        send_pad(2);
        send_frame(32'h2468_ACE0, -1, 256);
        repeat (2) @(posedge clk);
        #1;
        check("resume_last_good", 32'(last_good), 32'h1);

        // reset in the middle of a frame
        send_frame(32'h1357_9BDF, -1, 256);
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_last_good", 32'(last_good), 32'h2);
        send_frame(32'hF0E1_D2C3, -1, 100);
        #3 rst_n = 1'b0;
        #1;
        check("midreset_addr",      32'(ram_write_addr), 32'h0);
        check("midreset_data",      32'(ram_data), 32'h0);
        check("midreset_we",        32'(ram_we), 32'h0);
        check("midreset_last_good", 32'(last_good), 32'h0);
        check("midreset_locked",    32'(locked), 32'h0);
        check("midreset_frame_err", 32'(frame_error), 32'h0);
        check("midreset_queue",     32'(exp_q.size()), 32'h0);
        bclk = 1'b0; lrclk = 1'b0; data = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        exp_frame = '0;
        send_pad(4);
        send_frame(32'hA5A5_A5A5, -1, 256);
        send_frame(32'h0000_FFFF, -1, 256);
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_last_good", 32'(last_good), 32'h1);
        check("post_reset_locked",    32'(locked), 32'h1);

        repeat (4) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_msb_receiver.md
I2S_MSB_RECEIVER -- requirements
Module: i2s_msb_receiver

Interface
REQ-001 SHALL have parameter CIRC_BUF_BITS, default 3: log2 of frame slots in the circular RAM.
REQ-002 SHALL have parameter WDOG_CYCLES, default 64: clk_i cycles without a bclk rising edge before lock is dropped.
REQ-003 SHALL have port clk_i, input, 1: single clock; SHALL be at least 4x the bclk frequency.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port enable_i, input, 1: receive enable; low forces StIdle.
REQ-006 SHALL have port i2s_bclk_i, input, 1: asynchronous bit clock.
REQ-007 SHALL have port i2s_lrclk_i, input, 1: asynchronous word clock; high = left.
REQ-008 SHALL have port i2s_data_i, input, 1: asynchronous serial data, MSB-justified.
REQ-009 SHALL have port ram_write_addr_o, output, CIRC_BUF_BITS+8: {write frame, bit index}.
REQ-010 SHALL have port ram_data_o, output, 1: captured bit.
REQ-011 SHALL have port ram_we_o, output, 1: single-cycle write strobe.
REQ-012 SHALL have port last_good_frame_idx_o, output, CIRC_BUF_BITS: index of the newest complete frame.
REQ-013 SHALL have port locked_o, output, 1: high while in StCapture.
REQ-014 SHALL have port frame_error_o, output, 1: one-cycle pulse when a frame is discarded.

Function
REQ-015 SHALL pass bclk, lrclk and data through 2-flop synchronizers, then detect bclk rising edges on the synchronized signal.
REQ-016 SHALL sample data and lrclk on each detected bclk rising edge; ram_we_o SHALL assert exactly 3 clk_i cycles after the bclk pin rising edge.
REQ-017 SHALL treat a frame as 256 bits (8 slots x 32 bits; lrclk toggles every 32 bits), bit index 0..255, MSB of each slot first.
REQ-018 SHALL implement states StIdle, StSeek and StCapture.
REQ-019 StIdle SHALL go to StSeek when enable_i is high.
REQ-020 StSeek SHALL go to StCapture on a sampled lrclk 0->1 transition; that bit SHALL be written as bit index 0.
REQ-021 In StCapture, each sampled bit SHALL be written at {write frame, bit index}, and the bit index SHALL then increment modulo 256.
REQ-022 Frame completion: when bit 255 is written, last_good_frame_idx_o SHALL take the write frame one cycle later, and the write frame SHALL increment modulo 2^CIRC_BUF_BITS.
REQ-023 An lrclk transition at a bit index that is not a multiple of 32, or a missing transition at a multiple of 32 (index > 0), SHALL be a misalignment.
REQ-024 On misalignment: no write for that bit, pulse frame_error_o, go to StSeek, reset the bit index to 0, hold the write frame so the partial frame is overwritten, and leave last_good_frame_idx_o unchanged.
REQ-025 enable_i low in any state SHALL go to StIdle next cycle and abort the partial frame without a frame_error_o pulse.
REQ-026 ram_we_o SHALL be low outside StCapture.

Reset
REQ-027 rst_ni low SHALL asynchronously clear the state to StIdle, the bit index, the write frame, last_good_frame_idx_o, the synchronizers and the watchdog counter.
REQ-028 During reset, all outputs SHALL be 0.
REQ-029 Reset mid-frame SHALL discard the frame; after release, capture SHALL start at write frame 0.

Configuration
REQ-030 With I2S_RX_WATCHDOG_EN defined, in StCapture a counter SHALL count clk_i cycles since the last bclk rising edge.
REQ-031 When that counter reaches WDOG_CYCLES, the block SHALL take the misalignment path (REQ-024).
REQ-032 Without I2S_RX_WATCHDOG_EN, no counter SHALL exist, and a stalled bclk SHALL hold StCapture indefinitely.

Structure
REQ-033 Shared package i2s_pkg SHALL hold the state enum type, FRAME_BITS=256 and SLOT_BITS=32.
REQ-034 Sub-module i2s_input_sync SHALL contain the three synchronizers and the bclk edge detector.

Verification
REQ-035 Reset then enable, followed by 2 full aligned frames -> 512 writes; bit 0 goes to address 0x000; last_good_frame_idx_o = 0 then 1.
REQ-036 Frame pattern 0xA5A5A5A5 per slot -> RAM contents match bit-for-bit, MSB at slot bit 0.
REQ-037 lrclk toggled early at bit 40 -> frame_error_o pulses once; no write for bit 40; last_good_frame_idx_o unchanged; next lrclk 0->1 restarts capture at index 0 of the same frame.
REQ-038 9 consecutive frames with CIRC_BUF_BITS=3 -> write frame wraps 7->0; last_good_frame_idx_o = 0 after frame 9.
REQ-039 bclk stopped for 100 clk_i cycles mid-frame, with I2S_RX_WATCHDOG_EN -> locked_o falls after 64 cycles; without the macro -> locked_o stays high.
REQ-040 rst_ni asserted at bit 100 of frame 2 -> all outputs 0 immediately; after release, capture restarts at frame 0.
